// File: rtl/data_mem_unit.sv
// data_mem_unit
//   Clocked data memory for the CPU load/store stage. A request is accepted
//   through a valid/ready handshake, held for WAIT_STATES cycles, then the
//   array is accessed once and a one-cycle response pulse is produced.
//   Supports byte / halfword / word accesses with sign or zero extension on
//   loads.
//
// Parameters
//   DEPTH_LOG2   array holds 2**DEPTH_LOG2 32-bit words
//   WAIT_STATES  extra cycles between acceptance and array access (0..15)
//
// Optional feature macro
//   DMEM_ALIGN_CHECK_EN  when defined, misaligned half/word accesses and the
//                        reserved size 2'b11 are reported through rsp_err and
//                        perform no write. When undefined, rsp_err is 0,
//                        halfwords ignore addr[0], words ignore addr[1:0] and
//                        size 2'b11 acts as a word.
//
// Ports
//   clk, rst     rising-edge clock, synchronous active-high reset
//   req_valid    request present          req_ready  high only while idle
//   req_we       1 = store, 0 = load      req_size   00 byte, 01 half, 10 word
//   req_signed   load sign-extension      req_addr   byte address
//   req_wdata    right-aligned store data
//   rsp_valid    one-cycle completion pulse
//   rsp_rdata    load result (0 for stores and faults)
//   rsp_err      alignment/size fault, qualified by rsp_valid
//   busy         high while a request is in flight (WAIT or RESP)
module data_mem_unit #(
  parameter int DEPTH_LOG2  = 4,
  parameter int WAIT_STATES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [1:0]            req_size,
  input  logic                  req_signed,
  input  logic [DEPTH_LOG2+1:0] req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  rsp_valid,
  output logic [31:0]           rsp_rdata,
  output logic                  rsp_err,
  output logic                  busy
);

  localparam int AW    = DEPTH_LOG2 + 2;
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [3:0] WAIT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic [3:0]  wait_cnt, wait_cnt_nxt;
  logic        access;

  // Captured request fields (data path, not reset)
  logic          cap_we;
  logic [1:0]    cap_size;
  logic          cap_signed;
  logic [AW-1:0] cap_addr;
  logic [31:0]   cap_wdata;

  // Fields used at the access edge
  logic          acc_we;
  logic [1:0]    acc_size;
  logic          acc_signed;
  logic [AW-1:0] acc_addr;
  logic [31:0]   acc_wdata;
  logic          acc_fault;
  logic [3:0]    acc_be;
  logic [31:0]   acc_wrep;
  logic [DEPTH_LOG2-1:0] acc_widx;
  logic          mem_write;

  logic [31:0] mem [DEPTH];

  // Byte lanes touched by an access of the given size at the given lane.
  function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] lo);
    logic [3:0] m;
    case (size)
      2'b00:   m = 4'b0001 << lo;
      2'b01:   m = lo[1] ? 4'b1100 : 4'b0011;
      default: m = 4'b1111;
    endcase
    return m;
  endfunction

  // Store data replicated so every candidate lane sees the right bytes.
  function automatic logic [31:0] store_replicate(input logic [1:0] size, input logic [31:0] d);
    logic [31:0] r;
    case (size)
      2'b00:   r = {4{d[7:0]}};
      2'b01:   r = {2{d[15:0]}};
      default: r = d;
    endcase
    return r;
  endfunction

  // Select lanes from the stored word and extend to 32 bits.
  function automatic logic [31:0] load_extract(input logic [31:0] w, input logic [1:0] lo,
                                               input logic [1:0] size, input logic sgn);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    logic [31:0]        r;
    case (lo)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      default: b = w[31:24];
    endcase
    h = lo[1] ? w[31:16] : w[15:0];
    case (size)
      2'b00:   r = sgn ? 32'(b) : {24'd0, b};
      2'b01:   r = sgn ? 32'(h) : {16'd0, h};
      default: r = w;
    endcase
    return r;
  endfunction

  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lo);
    logic f;
    case (size)
      2'b00:   f = 1'b0;
      2'b01:   f = lo[0];
      2'b10:   f = (lo != 2'b00);
      default: f = 1'b1;
    endcase
    return f;
  endfunction

  // Next-state logic; access marks the single edge that touches the array
  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    access       = 1'b0;
    case (state)
      IDLE: begin
        if (req_valid) begin
          if (WAIT_STATES == 0) begin
            access    = 1'b1;
            state_nxt = RESP;
          end else begin
            state_nxt    = WAIT;
            wait_cnt_nxt = WAIT_INIT;
          end
        end
      end
      WAIT: begin
        if (wait_cnt == 4'd0) begin
          access    = 1'b1;
          state_nxt = RESP;
        end else begin
          wait_cnt_nxt = wait_cnt - 4'd1;
        end
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // With zero wait states the access uses the live request on the accept edge
  always_comb begin
    if (state == IDLE) begin
      acc_we     = req_we;
      acc_size   = req_size;
      acc_signed = req_signed;
      acc_addr   = req_addr;
      acc_wdata  = req_wdata;
    end else begin
      acc_we     = cap_we;
      acc_size   = cap_size;
      acc_signed = cap_signed;
      acc_addr   = cap_addr;
      acc_wdata  = cap_wdata;
    end
  end

`ifdef DMEM_ALIGN_CHECK_EN
  assign acc_fault = is_misaligned(acc_size, acc_addr[1:0]);
`else
  assign acc_fault = 1'b0;
`endif

  assign acc_widx  = acc_addr[AW-1:2];
  assign acc_be    = acc_fault ? 4'b0000 : lane_mask(acc_size, acc_addr[1:0]);
  assign acc_wrep  = store_replicate(acc_size, acc_wdata);
  assign mem_write = access && acc_we && !acc_fault && !rst;

  // Control registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      wait_cnt  <= 4'd0;
      rsp_valid <= 1'b0;
      rsp_rdata <= 32'd0;
      rsp_err   <= 1'b0;
    end else begin
      state     <= state_nxt;
      wait_cnt  <= wait_cnt_nxt;
      rsp_valid <= access;
      if (access) begin
        rsp_err   <= acc_fault;
        rsp_rdata <= (acc_we || acc_fault) ? 32'd0
                   : load_extract(mem[acc_widx], acc_addr[1:0], acc_size, acc_signed);
      end
    end
  end

  // Request capture
  always_ff @(posedge clk) begin
    if (state == IDLE && req_valid) begin
      cap_we     <= req_we;
      cap_size   <= req_size;
      cap_signed <= req_signed;
      cap_addr   <= req_addr;
      cap_wdata  <= req_wdata;
    end
  end

  // Memory array: per-lane writes, contents never reset
  always_ff @(posedge clk) begin
    if (mem_write) begin
      for (int i = 0; i < 4; i++) begin
        if (acc_be[i]) mem[acc_widx][8*i +: 8] <= acc_wrep[8*i +: 8];
      end
    end
  end

  assign req_ready = (state == IDLE);
  assign busy      = (state == WAIT) || (state == RESP);

  // is_misaligned is only referenced when the alignment check is built in
  logic unused_fn;
  assign unused_fn = is_misaligned(2'b00, 2'b00);

endmodule

// File: tb/tb_data_mem_unit.sv
module tb_data_mem_unit;

  localparam int DL2 = 4;
  localparam int WS  = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_we = 1'b0;
  logic [1:0]    req_size = 2'b00;
  logic          req_signed = 1'b0;
  logic [DL2+1:0] req_addr = '0;
  logic [31:0]   req_wdata = '0;
  logic          rsp_valid;
  logic [31:0]   rsp_rdata;
  logic          rsp_err;
  logic          busy;

  data_mem_unit #(.DEPTH_LOG2(DL2), .WAIT_STATES(WS)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_size(req_size), .req_signed(req_signed),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] rd;
    logic        err;
    int          acc;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;
  int   n_checks = 0;
  int   n_err = 0;
  int   n_rsp = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // Response monitor / scoreboard
  always @(negedge clk) begin
    if (!rst && rsp_valid) begin
      n_rsp++;
      if (exp_q.size() == 0) begin
        check("rsp_unexpected", 32'(rsp_valid), 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("rsp_rdata", rsp_rdata, e.rd);
        check("rsp_err", 32'(rsp_err), 32'(e.err));
        check("rsp_latency", 32'(cyc - e.acc + 1), 32'(WS + 1));
      end
    end
  end

  task automatic push_exp(input logic [31:0] rd, input logic err);
    exp_t x;
    x.rd  = rd;
    x.err = err;
    x.acc = cyc;
    exp_q.push_back(x);
  endtask

  task automatic wait_drain();
    int g = 0;
    while (exp_q.size() != 0 && g < 50) begin
      @(negedge clk);
      g++;
    end
    if (exp_q.size() != 0) begin
      check("rsp_timeout", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
    end
  endtask

  task automatic send(input logic we, input logic [1:0] size, input logic sgn,
                      input logic [DL2+1:0] addr, input logic [31:0] wdata,
                      input logic [31:0] exp_rd, input logic exp_err);
    int g = 0;
    @(negedge clk);
    while (!req_ready && g < 50) begin
      @(negedge clk);
      g++;
    end
    if (!req_ready) check("ready_timeout", 32'(req_ready), 32'd1);
    req_we     = we;
    req_size   = size;
    req_signed = sgn;
    req_addr   = addr;
    req_wdata  = wdata;
    req_valid  = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    push_exp(exp_rd, exp_err);
    wait_drain();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;

    // Reset
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_rdata", rsp_rdata, 32'd0);
    check("rst_rsp_err", 32'(rsp_err), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);

    // Word store/load
    send(1'b1, 2'b10, 1'b0, 6'h08, 32'hDEADBEEF, 32'h0, 1'b0);
    send(1'b0, 2'b10, 1'b0, 6'h08, 32'h0, 32'hDEADBEEF, 1'b0);

    // Byte store, signed/unsigned byte loads, word readback
    send(1'b1, 2'b00, 1'b0, 6'h09, 32'hFFFFFF80, 32'h0, 1'b0);
    send(1'b0, 2'b00, 1'b1, 6'h09, 32'h0, 32'hFFFFFF80, 1'b0);
    send(1'b0, 2'b00, 1'b0, 6'h09, 32'h0, 32'h00000080, 1'b0);
    send(1'b0, 2'b10, 1'b0, 6'h08, 32'h0, 32'hDEAD80EF, 1'b0);

    // Halfword store into zeroed word
    send(1'b1, 2'b10, 1'b0, 6'h0C, 32'h00000000, 32'h0, 1'b0);
    send(1'b1, 2'b01, 1'b0, 6'h0E, 32'hABCD1234, 32'h0, 1'b0);
    send(1'b0, 2'b01, 1'b1, 6'h0E, 32'h0, 32'h00001234, 1'b0);
    send(1'b0, 2'b10, 1'b0, 6'h0C, 32'h0, 32'h12340000, 1'b0);

    // Top lane byte, then negative half both ways, low half untouched
    send(1'b1, 2'b00, 1'b0, 6'h0F, 32'h000000AB, 32'h0, 1'b0);
    send(1'b0, 2'b01, 1'b1, 6'h0E, 32'h0, 32'hFFFFAB34, 1'b0);
    send(1'b0, 2'b01, 1'b0, 6'h0E, 32'h0, 32'h0000AB34, 1'b0);
    send(1'b0, 2'b01, 1'b1, 6'h0C, 32'h0, 32'h00000000, 1'b0);

    // Address wrap: 0x3C + word index wraps within depth 16 (index 15)
    send(1'b1, 2'b10, 1'b0, 6'h3C, 32'h5A5AA5A5, 32'h0, 1'b0);
    send(1'b0, 2'b00, 1'b1, 6'h3D, 32'h0, 32'hFFFFFFA5, 1'b0);

    // Request held through busy with a different address
    @(negedge clk);
    base = n_rsp;
    req_we = 1'b0; req_size = 2'b10; req_signed = 1'b0;
    req_addr = 6'h08; req_valid = 1'b1;
    @(posedge clk);
    #1;
    push_exp(32'hDEAD80EF, 1'b0);
    req_addr = 6'h0C;
    for (int i = 0; i < WS + 1; i++) begin
      @(negedge clk);
      check("hold_req_ready", 32'(req_ready), 32'd0);
      check("hold_busy", 32'(busy), 32'd1);
    end
    req_valid = 1'b0;
    @(negedge clk);
    check("hold_ready_after", 32'(req_ready), 32'd1);
    repeat (4) @(negedge clk);
    check("hold_rsp_count", 32'(n_rsp - base), 32'd1);
    check("hold_queue_empty", 32'(exp_q.size()), 32'd0);
    exp_q.delete();

    // Reset on the access edge of a store aborts it
    send(1'b1, 2'b10, 1'b0, 6'h04, 32'h11111111, 32'h0, 1'b0);
    @(negedge clk);
    base = n_rsp;
    req_we = 1'b1; req_size = 2'b10; req_addr = 6'h04;
    req_wdata = 32'h22222222; req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("abort_req_ready", 32'(req_ready), 32'd1);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_rsp_valid", 32'(rsp_valid), 32'd0);
    repeat (5) @(negedge clk);
    check("abort_rsp_count", 32'(n_rsp - base), 32'd0);
    send(1'b0, 2'b10, 1'b0, 6'h04, 32'h0, 32'h11111111, 1'b0);

    // Misaligned word store
`ifdef DMEM_ALIGN_CHECK_EN
    send(1'b1, 2'b10, 1'b0, 6'h06, 32'hCAFEF00D, 32'h0, 1'b1);
    send(1'b0, 2'b10, 1'b0, 6'h04, 32'h0, 32'h11111111, 1'b0);
    send(1'b0, 2'b11, 1'b0, 6'h04, 32'h0, 32'h0, 1'b1);
`else
    send(1'b1, 2'b10, 1'b0, 6'h06, 32'hCAFEF00D, 32'h0, 1'b0);
    send(1'b0, 2'b10, 1'b0, 6'h04, 32'h0, 32'hCAFEF00D, 1'b0);
    send(1'b0, 2'b11, 1'b0, 6'h04, 32'h0, 32'hCAFEF00D, 1'b0);
`endif

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
